// File: rtl/cbus_mst_if_pkg.sv
// Shared types and constants for the CBUS master engine of the AXI-to-CBUS bridge.
// FIFO word layouts are defined as packed structs so every user slices them the same way.
package cbus_mst_if_pkg;

   localparam int A2C_LEN_BITS = 8;
   localparam int A2C_ID_W     = 4;
   localparam int A2C_USER_W   = 4;

   localparam logic [1:0] A2C_OKAY   = 2'b00;
   localparam logic [1:0] A2C_SLVERR = 2'b10;

   localparam logic [1:0] A2C_BURST_FIXED = 2'b00;
   localparam logic [1:0] A2C_BURST_INCR  = 2'b01;
   localparam logic [1:0] A2C_BURST_WRAP  = 2'b10;

   // Command FIFO word: {user, id, rd, burst, len, addr}
   typedef struct packed {
      logic [A2C_USER_W-1:0]   user;
      logic [A2C_ID_W-1:0]     id;
      logic                    rd;
      logic [1:0]              burst;
      logic [A2C_LEN_BITS-1:0] len;
      logic [31:0]             addr;
   } a2c_cmd_t;

   // Write data FIFO word: {wlast, wstrb, wdata}
   typedef struct packed {
      logic        wlast;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
   } a2c_wbeat_t;

   // Read data FIFO word: {user, id, rlast, rresp, rdata}
   typedef struct packed {
      logic [A2C_USER_W-1:0] user;
      logic [A2C_ID_W-1:0]   id;
      logic                  rlast;
      logic [1:0]            rresp;
      logic [31:0]           rdata;
   } a2c_rbeat_t;

   localparam int A2C_CWFIFO_DW = $bits(a2c_cmd_t);
   localparam int A2C_DWFIFO_DW = $bits(a2c_wbeat_t);
   localparam int A2C_RDFIFO_DW = $bits(a2c_rbeat_t);

   // Byte-offset mask of a wrap window of (len+1) 4-byte beats; len+1 is a power of two
   function automatic logic [31:0] a2c_wrap_mask(input logic [A2C_LEN_BITS-1:0] len);
      return {{(32-A2C_LEN_BITS-2){1'b0}}, len, 2'b11};
   endfunction

endpackage

// File: rtl/a2c_addr_gen.sv
// Next-beat address for 4-byte CBUS beats under FIXED, INCR and WRAP bursts.
// The reserved burst encoding behaves like INCR.
module a2c_addr_gen
   import cbus_mst_if_pkg::*;
(
   input  logic [31:0]             addr_i,
   input  logic [A2C_LEN_BITS-1:0] len_i,
   input  logic [1:0]              burst_i,
   output logic [31:0]             next_addr_o
);

   logic [31:0] incr_addr;
   logic [31:0] wrap_mask;

   // Select the following beat address; WRAP keeps the upper bits and wraps the window offset
   always_comb begin
      incr_addr = addr_i + 32'd4;
      wrap_mask = a2c_wrap_mask(len_i);
      case (burst_i)
         A2C_BURST_FIXED: next_addr_o = addr_i;
         A2C_BURST_WRAP:  next_addr_o = (addr_i & ~wrap_mask) | (incr_addr & wrap_mask);
         default:         next_addr_o = incr_addr;
      endcase
   end

endmodule

// File: rtl/cbus_mst_if.sv
// CBUS master engine: pops AXI commands and write beats, runs one single-beat CBUS
// access per AXI beat, and returns read beats (with resp/last/id/user) to the read FIFO.
// Only one transaction is in flight; every CBUS access waits for ack or a timeout.
module cbus_mst_if
   import cbus_mst_if_pkg::*;
#(
   parameter int unsigned TMO_CYC = 256,
   parameter int unsigned TMO_W   = 9
)
(
   input  logic                     aclk,
   input  logic                     areset,
   input  logic [A2C_CWFIFO_DW-1:0] cwfifo_dataout,
   input  logic                     cwfifo_empty,
   output logic                     cwfifo_rd_op,
   input  logic [A2C_DWFIFO_DW-1:0] dwfifo_dataout,
   input  logic                     dwfifo_empty,
   output logic                     dwfifo_rd_op,
   output logic [A2C_RDFIFO_DW-1:0] rdfifo_datain,
   output logic                     rdfifo_wr_op,
   input  logic                     rdfifo_full,
   output logic [31:0]              cbus_addr,
   output logic                     cbus_wr,
   output logic                     cbus_rd,
   output logic [31:0]              cbus_wdata,
   output logic [3:0]               cbus_be,
   input  logic                     cbus_ack,
   input  logic                     cbus_err,
   input  logic [31:0]              cbus_rdata,
   output logic                     wr_err
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] WR_WAIT = 3'd1;
   localparam logic [2:0] WR_ACK  = 3'd2;
   localparam logic [2:0] RD_WAIT = 3'd3;
   localparam logic [2:0] RD_ACK  = 3'd4;

   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

   a2c_cmd_t   cmd;
   a2c_wbeat_t wbeat;

   logic [2:0]              state_q,     state_d;
   logic [31:0]             addr_q,      addr_d;
   logic [A2C_LEN_BITS-1:0] len_q,       len_d;
   logic [1:0]              burst_q,     burst_d;
   logic [A2C_ID_W-1:0]     id_q,        id_d;
   logic [A2C_USER_W-1:0]   user_q,      user_d;
   logic [A2C_LEN_BITS-1:0] beat_cnt_q,  beat_cnt_d;
   logic                    wlast_q,     wlast_d;
   logic                    cbus_wr_q,   cbus_wr_d;
   logic                    cbus_rd_q,   cbus_rd_d;
   logic [31:0]             wdata_q,     wdata_d;
   logic [3:0]              be_q,        be_d;
   a2c_rbeat_t              rbeat_q,     rbeat_d;
   logic                    rd_push_q,   rd_push_d;
   logic                    wr_err_q,    wr_err_d;
   logic [TMO_W-1:0]        tmo_cnt_q,   tmo_cnt_d;

   logic [31:0] next_addr;
   logic        tmo_hit;
   logic        done;
   logic        fail;

   assign cmd   = cwfifo_dataout;
   assign wbeat = dwfifo_dataout;

   a2c_addr_gen u_addr_gen (
      .addr_i      (addr_q),
      .len_i       (len_q),
      .burst_i     (burst_q),
      .next_addr_o (next_addr)
   );

   assign cbus_addr     = addr_q;
   assign cbus_wr       = cbus_wr_q;
   assign cbus_rd       = cbus_rd_q;
   assign cbus_wdata    = wdata_q;
   assign cbus_be       = be_q;
   assign rdfifo_datain = rbeat_q;
   assign rdfifo_wr_op  = rd_push_q;
   assign wr_err        = wr_err_q;

   // Access completion: ack ends the access, timeout only matters when ack is absent
   always_comb begin
      tmo_hit = (TMO_CYC != 0) && (tmo_cnt_q == TMO_LAST);
      done    = cbus_ack || tmo_hit;
      fail    = cbus_ack ? cbus_err : 1'b1;
   end

   // Transaction sequencing, FIFO pops and next values of every registered output
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      len_d        = len_q;
      burst_d      = burst_q;
      id_d         = id_q;
      user_d       = user_q;
      beat_cnt_d   = beat_cnt_q;
      wlast_d      = wlast_q;
      cbus_wr_d    = cbus_wr_q;
      cbus_rd_d    = cbus_rd_q;
      wdata_d      = wdata_q;
      be_d         = be_q;
      rbeat_d      = rbeat_q;
      rd_push_d    = 1'b0;
      wr_err_d     = 1'b0;
      tmo_cnt_d    = tmo_cnt_q;
      cwfifo_rd_op = 1'b0;
      dwfifo_rd_op = 1'b0;

      case (state_q)
         IDLE: begin
            if (!cwfifo_empty) begin
               cwfifo_rd_op = 1'b1;
               addr_d       = cmd.addr;
               len_d        = cmd.len;
               burst_d      = cmd.burst;
               id_d         = cmd.id;
               user_d       = cmd.user;
               beat_cnt_d   = '0;
               state_d      = cmd.rd ? RD_WAIT : WR_WAIT;
            end
         end
         WR_WAIT: begin
            if (!dwfifo_empty) begin
               dwfifo_rd_op = 1'b1;
               cbus_wr_d    = 1'b1;
               wdata_d      = wbeat.wdata;
               be_d         = wbeat.wstrb;
               wlast_d      = wbeat.wlast;
               tmo_cnt_d    = '0;
               state_d      = WR_ACK;
            end
         end
         WR_ACK: begin
            if (done) begin
               cbus_wr_d = 1'b0;
               wr_err_d  = fail;
               if (wlast_q) begin
                  state_d = IDLE;
               end else begin
                  addr_d  = next_addr;
                  state_d = WR_WAIT;
               end
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
         end
         RD_WAIT: begin
            if (!rdfifo_full) begin
               cbus_rd_d = 1'b1;
               be_d      = 4'hF;
               tmo_cnt_d = '0;
               state_d   = RD_ACK;
            end
         end
         RD_ACK: begin
            if (done) begin
               cbus_rd_d     = 1'b0;
               rd_push_d     = 1'b1;
               rbeat_d.user  = user_q;
               rbeat_d.id    = id_q;
               rbeat_d.rlast = (beat_cnt_q == len_q);
               rbeat_d.rresp = fail ? A2C_SLVERR : A2C_OKAY;
               rbeat_d.rdata = cbus_ack ? cbus_rdata : 32'd0;
               if (beat_cnt_q == len_q) begin
                  state_d = IDLE;
               end else begin
                  beat_cnt_d = beat_cnt_q + 1'b1;
                  addr_d     = next_addr;
                  state_d    = RD_WAIT;
               end
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d   = IDLE;
            cbus_wr_d = 1'b0;
            cbus_rd_d = 1'b0;
         end
      endcase
   end

   // State and output registers; reset drops any strobe immediately
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         len_q      <= '0;
         burst_q    <= '0;
         id_q       <= '0;
         user_q     <= '0;
         beat_cnt_q <= '0;
         wlast_q    <= 1'b0;
         cbus_wr_q  <= 1'b0;
         cbus_rd_q  <= 1'b0;
         wdata_q    <= '0;
         be_q       <= '0;
         rbeat_q    <= '0;
         rd_push_q  <= 1'b0;
         wr_err_q   <= 1'b0;
         tmo_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         len_q      <= len_d;
         burst_q    <= burst_d;
         id_q       <= id_d;
         user_q     <= user_d;
         beat_cnt_q <= beat_cnt_d;
         wlast_q    <= wlast_d;
         cbus_wr_q  <= cbus_wr_d;
         cbus_rd_q  <= cbus_rd_d;
         wdata_q    <= wdata_d;
         be_q       <= be_d;
         rbeat_q    <= rbeat_d;
         rd_push_q  <= rd_push_d;
         wr_err_q   <= wr_err_d;
         tmo_cnt_q  <= tmo_cnt_d;
      end
   end

endmodule

// File: tb/tb_cbus_mst_if.sv
// Directed bench for cbus_mst_if: behavioural command/data FIFOs, a CBUS slave with
// configurable wait states / error / no-ack, and monitors for accesses and read pushes.
`timescale 1ns/1ps
module tb_cbus_mst_if;

   localparam int CW = 51;
   localparam int DW = 37;
   localparam int RW = 43;

   logic          aclk;
   logic          areset;
   logic [CW-1:0] cwfifo_dataout;
   logic          cwfifo_empty;
   logic          cwfifo_rd_op;
   logic [DW-1:0] dwfifo_dataout;
   logic          dwfifo_empty;
   logic          dwfifo_rd_op;
   logic [RW-1:0] rdfifo_datain;
   logic          rdfifo_wr_op;
   logic          rdfifo_full;
   logic [31:0]   cbus_addr;
   logic          cbus_wr;
   logic          cbus_rd;
   logic [31:0]   cbus_wdata;
   logic [3:0]    cbus_be;
   logic          cbus_ack;
   logic          cbus_err;
   logic [31:0]   cbus_rdata;
   logic          wr_err;

   cbus_mst_if #(.TMO_CYC(8), .TMO_W(9)) dut (
      .aclk           (aclk),
      .areset         (areset),
      .cwfifo_dataout (cwfifo_dataout),
      .cwfifo_empty   (cwfifo_empty),
      .cwfifo_rd_op   (cwfifo_rd_op),
      .dwfifo_dataout (dwfifo_dataout),
      .dwfifo_empty   (dwfifo_empty),
      .dwfifo_rd_op   (dwfifo_rd_op),
      .rdfifo_datain  (rdfifo_datain),
      .rdfifo_wr_op   (rdfifo_wr_op),
      .rdfifo_full    (rdfifo_full),
      .cbus_addr      (cbus_addr),
      .cbus_wr        (cbus_wr),
      .cbus_rd        (cbus_rd),
      .cbus_wdata     (cbus_wdata),
      .cbus_be        (cbus_be),
      .cbus_ack       (cbus_ack),
      .cbus_err       (cbus_err),
      .cbus_rdata     (cbus_rdata),
      .wr_err         (wr_err)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   logic [CW-1:0] cwQ[$];
   logic [DW-1:0] dwQ[$];

   int testsRun = 0;
   int failures = 0;

   int cyc = 0;
   int popCyc = 0;
   logic cwPopPending = 1'b0;
   logic dwPopPending = 1'b0;

   int ackWait = 0;
   logic ackErr = 1'b0;
   logic noAck = 1'b0;
   logic inAcc = 1'b0;
   int waitCnt = 0;

   int accN = 0;
   logic [31:0] accAddr[64];
   logic [3:0]  accBe[64];
   logic [31:0] accWdata[64];
   logic        accWr[64];
   int          accHigh[64];
   int          accStart[64];

   int pushN = 0;
   logic [RW-1:0] pushData[64];
   int wrErrCnt = 0;

   function automatic logic [31:0] rdModel(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [CW-1:0] mkCmd(input logic [31:0] addr, input logic [7:0] len,
                                           input logic [1:0] burst, input logic rd,
                                           input logic [3:0] id, input logic [3:0] user);
      return {user, id, rd, burst, len, addr};
   endfunction

   task automatic refreshFifos();
      cwfifo_empty   = (cwQ.size() == 0);
      cwfifo_dataout = (cwQ.size() != 0) ? cwQ[0] : '0;
      dwfifo_empty   = (dwQ.size() == 0);
      dwfifo_dataout = (dwQ.size() != 0) ? dwQ[0] : '0;
   endtask

   task automatic applyStimulus(input logic [CW-1:0] c);
      cwQ.push_back(c);
      refreshFifos();
   endtask

   task automatic pushBeat(input logic wlast, input logic [3:0] strb, input logic [31:0] data);
      dwQ.push_back({wlast, strb, data});
      refreshFifos();
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      testsRun++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge aclk);
      #2;
   endtask

   task automatic waitAccs(input int target, input int budget);
      for (int i = 0; i < budget && accN < target; i++) tick(1);
   endtask

   task automatic waitPushes(input int target, input int budget);
      for (int i = 0; i < budget && pushN < target; i++) tick(1);
   endtask

   // FIFO pops, CBUS slave model and output monitors, all evaluated mid-cycle
   always begin
      @(negedge aclk);
      cyc++;
      if (cwPopPending && cwQ.size() != 0) void'(cwQ.pop_front());
      if (dwPopPending && dwQ.size() != 0) void'(dwQ.pop_front());
      refreshFifos();
      if (cbus_wr || cbus_rd) begin
         if (!inAcc) begin
            accAddr[accN]  = cbus_addr;
            accBe[accN]    = cbus_be;
            accWdata[accN] = cbus_wdata;
            accWr[accN]    = cbus_wr;
            accHigh[accN]  = 0;
            accStart[accN] = cyc;
            accN++;
            inAcc   = 1'b1;
            waitCnt = 0;
         end
         accHigh[accN-1]++;
         if (!noAck && waitCnt == ackWait) begin
            cbus_ack   = 1'b1;
            cbus_err   = ackErr;
            cbus_rdata = rdModel(cbus_addr);
         end else begin
            cbus_ack   = 1'b0;
            cbus_err   = 1'b0;
            cbus_rdata = 32'hDEAD_BEEF;
         end
         waitCnt++;
      end else begin
         inAcc      = 1'b0;
         cbus_ack   = 1'b0;
         cbus_err   = 1'b0;
         cbus_rdata = 32'hDEAD_BEEF;
      end
      if (rdfifo_wr_op) begin
         pushData[pushN] = rdfifo_datain;
         pushN++;
      end
      if (wr_err) wrErrCnt++;
      #4;
      cwPopPending = cwfifo_rd_op;
      dwPopPending = dwfifo_rd_op;
      if (cwfifo_rd_op) popCyc = cyc;
   end

   initial begin
      int a0;
      int p0;
      logic [31:0] expAddr[4];
      logic [3:0]  expBe[4];

      areset      = 1'b1;
      rdfifo_full = 1'b0;
      cbus_ack    = 1'b0;
      cbus_err    = 1'b0;
      cbus_rdata  = 32'hDEAD_BEEF;
      refreshFifos();

      // Reset state
      tick(3);
      checkOutput("rst_cbus_wr", cbus_wr, 0);
      checkOutput("rst_cbus_rd", cbus_rd, 0);
      checkOutput("rst_cbus_addr", cbus_addr, 0);
      checkOutput("rst_cbus_be", cbus_be, 0);
      checkOutput("rst_rdfifo_wr_op", rdfifo_wr_op, 0);
      checkOutput("rst_rdfifo_datain", rdfifo_datain, 0);
      checkOutput("rst_wr_err", wr_err, 0);
      areset = 1'b0;
      tick(2);

      // Write INCR 0x100 len 3, zero-wait ack
      ackWait = 0;
      pushBeat(1'b0, 4'hF, 32'h1111_1111);
      pushBeat(1'b0, 4'h3, 32'h2222_2222);
      pushBeat(1'b0, 4'hC, 32'h3333_3333);
      pushBeat(1'b1, 4'hF, 32'h4444_4444);
      applyStimulus(mkCmd(32'h100, 8'd3, 2'b01, 1'b0, 4'h1, 4'h2));
      waitAccs(4, 100);
      tick(4);
      checkOutput("wr_incr_count", accN, 4);
      expAddr = '{32'h100, 32'h104, 32'h108, 32'h10C};
      expBe   = '{4'hF, 4'h3, 4'hC, 4'hF};
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("wr_incr_addr%0d", i), accAddr[i], expAddr[i]);
         checkOutput($sformatf("wr_incr_be%0d", i), accBe[i], expBe[i]);
         checkOutput($sformatf("wr_incr_wdata%0d", i), accWdata[i], {4{4'(i + 1), 4'(i + 1)}});
         checkOutput($sformatf("wr_incr_iswr%0d", i), accWr[i], 1);
         checkOutput($sformatf("wr_incr_high%0d", i), accHigh[i], 1);
      end
      checkOutput("wr_incr_first_strobe_lat", accStart[0] - popCyc, 2);
      checkOutput("wr_incr_beat_spacing", accStart[1] - accStart[0], 2);
      checkOutput("wr_incr_wr_err", wrErrCnt, 0);
      checkOutput("wr_incr_no_push", pushN, 0);

      // Read WRAP 0x208 len 3, two wait states; engine must be idle and pop at once
      ackWait = 2;
      a0 = accN;
      applyStimulus(mkCmd(32'h208, 8'd3, 2'b10, 1'b1, 4'h5, 4'hA));
      #1;
      checkOutput("idle_pop_immediate", cwfifo_rd_op, 1);
      waitPushes(4, 200);
      tick(3);
      checkOutput("rd_wrap_pushes", pushN, 4);
      expAddr = '{32'h208, 32'h20C, 32'h200, 32'h204};
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("rd_wrap_addr%0d", i), accAddr[a0 + i], expAddr[i]);
         checkOutput($sformatf("rd_wrap_be%0d", i), accBe[a0 + i], 4'hF);
         checkOutput($sformatf("rd_wrap_high%0d", i), accHigh[a0 + i], 3);
         checkOutput($sformatf("rd_wrap_rdata%0d", i), pushData[i][31:0], rdModel(expAddr[i]));
         checkOutput($sformatf("rd_wrap_rresp%0d", i), pushData[i][33:32], 2'b00);
         checkOutput($sformatf("rd_wrap_rlast%0d", i), pushData[i][34], (i == 3) ? 1 : 0);
         checkOutput($sformatf("rd_wrap_id%0d", i), pushData[i][38:35], 4'h5);
         checkOutput($sformatf("rd_wrap_user%0d", i), pushData[i][42:39], 4'hA);
      end

      // Read INCR 0x300 len 1 behind a full read FIFO
      ackWait = 0;
      rdfifo_full = 1'b1;
      a0 = accN;
      p0 = pushN;
      applyStimulus(mkCmd(32'h300, 8'd1, 2'b01, 1'b1, 4'h7, 4'h1));
      tick(10);
      checkOutput("rd_full_no_access", accN - a0, 0);
      checkOutput("rd_full_cbus_rd", cbus_rd, 0);
      rdfifo_full = 1'b0;
      waitPushes(p0 + 2, 100);
      tick(3);
      checkOutput("rd_full_pushes", pushN - p0, 2);
      checkOutput("rd_full_addr0", accAddr[a0], 32'h300);
      checkOutput("rd_full_addr1", accAddr[a0 + 1], 32'h304);
      checkOutput("rd_full_rlast0", pushData[p0][34], 0);
      checkOutput("rd_full_rlast1", pushData[p0 + 1][34], 1);
      checkOutput("rd_full_rdata1", pushData[p0 + 1][31:0], rdModel(32'h304));

      // Write FIXED len 0 with error response
      ackErr = 1'b1;
      a0 = accN;
      p0 = pushN;
      pushBeat(1'b1, 4'h5, 32'hCAFE_0001);
      applyStimulus(mkCmd(32'h400, 8'd0, 2'b00, 1'b0, 4'h0, 4'h0));
      waitAccs(a0 + 1, 100);
      tick(5);
      ackErr = 1'b0;
      checkOutput("wr_err_access", accN - a0, 1);
      checkOutput("wr_err_addr", accAddr[a0], 32'h400);
      checkOutput("wr_err_be", accBe[a0], 4'h5);
      checkOutput("wr_err_pulse_cycles", wrErrCnt, 1);
      checkOutput("wr_err_no_push", pushN - p0, 0);

      // Read without ack: timeout after 8 strobe cycles
      noAck = 1'b1;
      a0 = accN;
      p0 = pushN;
      applyStimulus(mkCmd(32'h500, 8'd0, 2'b01, 1'b1, 4'h2, 4'h3));
      waitPushes(p0 + 1, 100);
      tick(3);
      checkOutput("tmo_push", pushN - p0, 1);
      checkOutput("tmo_strobe_cycles", accHigh[a0], 8);
      checkOutput("tmo_rresp", pushData[p0][33:32], 2'b10);
      checkOutput("tmo_rdata", pushData[p0][31:0], 32'd0);
      checkOutput("tmo_rlast", pushData[p0][34], 1);
      checkOutput("tmo_id", pushData[p0][38:35], 4'h2);

      // Reset while a read waits for ack, then a normal read
      a0 = accN;
      p0 = pushN;
      applyStimulus(mkCmd(32'h600, 8'd1, 2'b01, 1'b1, 4'h4, 4'h4));
      for (int i = 0; i < 20 && cbus_rd !== 1'b1; i++) tick(1);
      checkOutput("rst_mid_rd_before", cbus_rd, 1);
      tick(2);
      areset = 1'b1;
      #1;
      checkOutput("rst_mid_rd_dropped", cbus_rd, 0);
      checkOutput("rst_mid_addr", cbus_addr, 0);
      tick(2);
      areset = 1'b0;
      noAck = 1'b0;
      ackWait = 1;
      tick(1);
      applyStimulus(mkCmd(32'h700, 8'd0, 2'b01, 1'b1, 4'h3, 4'h6));
      waitPushes(p0 + 1, 100);
      tick(5);
      checkOutput("post_rst_pushes", pushN - p0, 1);
      checkOutput("post_rst_addr", accAddr[a0 + 1], 32'h700);
      checkOutput("post_rst_rdata", pushData[p0][31:0], rdModel(32'h700));
      checkOutput("post_rst_rresp", pushData[p0][33:32], 2'b00);
      checkOutput("post_rst_rlast", pushData[p0][34], 1);
      checkOutput("post_rst_id", pushData[p0][38:35], 4'h3);
      checkOutput("post_rst_user", pushData[p0][42:39], 4'h6);

      $display("[TB] %0d tests run, %0d failed", testsRun, failures);
      $finish;
   end

endmodule
